// File: rtl/reset_sequencer.sv
// Reset release sequencer with a counted run/done phase for downstream logic.
// Optional build macro RESET_SEQUENCER_AUTORESTART_EN: DONE lasts one cycle, then a new run starts without start.
module reset_sequencer #(
    parameter int RST_CYCLES = 2,
    parameter int NUM_CYCLES = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    output logic        sync_reset,
    output logic        running,
    output logic        done,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_RESET,
        S_HOLD,
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0]  HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST  = 32'(NUM_CYCLES - 1);
    localparam logic [31:0] RUN_END   = 32'(NUM_CYCLES);

    state_t      state;
    logic [7:0]  hold_cnt;
    logic        sync_p0;
    logic        sync_p1;

    // Saturating step: the final increment lands exactly on NUM_CYCLES and never beyond.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        if (c >= RUN_LAST)
            return RUN_END;
        else
            return c + 32'd1;
    endfunction

    // Reset release synchroniser, stage p0 -> p1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= 1'b1;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_RESET;
            hold_cnt    <= 8'd0;
            cycle_count <= 32'd0;
            sync_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    if (sync_p1) begin
                        state    <= S_HOLD;
                        hold_cnt <= 8'd0;
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= S_IDLE;
                        sync_reset <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        running     <= 1'b1;
                        cycle_count <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        cycle_count <= sat_inc(cycle_count);
                        if (cycle_count == RUN_LAST) begin
                            state   <= S_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
`ifdef RESET_SEQUENCER_AUTORESTART_EN
                    state       <= S_RUN;
                    running     <= 1'b1;
                    done        <= 1'b0;
                    cycle_count <= 32'd0;
`else
                    if (start) begin
                        state       <= S_RUN;
                        running     <= 1'b1;
                        done        <= 1'b0;
                        cycle_count <= 32'd0;
                    end
`endif
                end
                default: begin
                    state       <= S_RESET;
                    hold_cnt    <= 8'd0;
                    cycle_count <= 32'd0;
                    sync_reset  <= 1'b1;
                    running     <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two parameterisations driven together, checked against an edge-counting model.
module tb_reset_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        sr_a, run_a, done_a;
    logic        sr_b, run_b, done_b;
    logic [31:0] cc_a, cc_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance: edges since release, run/done flags, count
    int rel [2];
    int cnt [2];
    bit act [2];
    bit dn  [2];

    always #5 clock = ~clock;

    reset_sequencer #(.RST_CYCLES(2), .NUM_CYCLES(5)) u_a (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .sync_reset(sr_a), .running(run_a), .done(done_a), .cycle_count(cc_a)
    );

    reset_sequencer #(.RST_CYCLES(1), .NUM_CYCLES(1)) u_b (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .sync_reset(sr_b), .running(run_b), .done(done_b), .cycle_count(cc_b)
    );

    function automatic int rcyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int ncyc(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rel[i] = 0; cnt[i] = 0; act[i] = 1'b0; dn[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit st, input bit pz);
        bit auto_rs;
`ifdef RESET_SEQUENCER_AUTORESTART_EN
        auto_rs = 1'b1;
`else
        auto_rs = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            if (rel[i] >= 3 + rcyc(i)) begin
                if (act[i]) begin
                    if (!pz) begin
                        cnt[i] = cnt[i] + 1;
                        if (cnt[i] == ncyc(i)) begin
                            act[i] = 1'b0;
                            dn[i]  = 1'b1;
                        end
                    end
                end else if (dn[i]) begin
                    if (auto_rs || st) begin
                        dn[i] = 1'b0; act[i] = 1'b1; cnt[i] = 0;
                    end
                end else if (st) begin
                    act[i] = 1'b1; cnt[i] = 0;
                end
            end
            if (rel[i] < 1000) rel[i] = rel[i] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.sync_reset",  {31'd0, sr_a},   {31'd0, (rel[0] < 3 + rcyc(0))});
        chk("a.running",     {31'd0, run_a},  {31'd0, act[0]});
        chk("a.done",        {31'd0, done_a}, {31'd0, dn[0]});
        chk("a.cycle_count", cc_a,            32'(cnt[0]));
        chk("b.sync_reset",  {31'd0, sr_b},   {31'd0, (rel[1] < 3 + rcyc(1))});
        chk("b.running",     {31'd0, run_b},  {31'd0, act[1]});
        chk("b.done",        {31'd0, done_b}, {31'd0, dn[1]});
        chk("b.cycle_count", cc_b,            32'(cnt[1]));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the falling edge
    task automatic step(input bit st, input bit pz);
        start = st;
        pause = pz;
        @(posedge clock);
        if (reset) model_edge(st, pz);
        @(negedge clock);
        check_all();
    endtask

    // Sub-period reset pulse issued from the falling edge
    task automatic glitch();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #3;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);

        reset = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("a.done_holds", {31'd0, done_a}, 32'd1);
        chk("a.count_holds", cc_a, 32'd5);

        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        glitch();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);

        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) glitch();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of clock cycles sync_reset is held after the synchronised reset release; legal range 1..255.
REQ-002 SHALL have parameter NUM_CYCLES, default 50: run length in clock cycles per run; legal range 1..1000000000.
REQ-003 SHALL have port clock  input  1  single system clock; all flops rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a run, sampled on the rising clock edge.
REQ-006 SHALL have port pause  input  1  freeze the run counter while high.
REQ-007 SHALL have port sync_reset  output  1  active-high synchronous reset for downstream logic.
REQ-008 SHALL have port running  output  1  high while state is RUN.
REQ-009 SHALL have port done  output  1  high while state is DONE.
REQ-010 SHALL have port cycle_count  output  32  unpaused cycles counted in the current or last run.

Function
REQ-011 SHALL synchronise reset release through a 2-flop chain; both flops clear asynchronously when reset is low; output rises on the 2nd rising edge after reset goes high.
REQ-012 SHALL implement states RESET, HOLD, IDLE, RUN and DONE, one-hot or binary encoded; all outputs SHALL be registered.
REQ-013 SHALL transition RESET->HOLD on the first edge at which the synchroniser output is high, i.e. the 3rd edge after release.
REQ-014 SHALL clear the 8-bit hold counter on entry to HOLD, increment it each cycle, and transition HOLD->IDLE when it equals RST_CYCLES-1.
REQ-015 SHALL drive sync_reset high in RESET and HOLD and low otherwise; sync_reset falls on edge 3+RST_CYCLES after release.
REQ-016 In IDLE with start=1: SHALL transition to RUN and load cycle_count=0 on the same edge.
REQ-017 In RUN: SHALL increment cycle_count by 1 per edge with pause=0 and hold it with pause=1.
REQ-018 In RUN with pause=0 and cycle_count=NUM_CYCLES-1: SHALL load cycle_count=NUM_CYCLES and transition to DONE on the same edge.
REQ-019 With NUM_CYCLES=1: RUN SHALL last exactly one unpaused cycle.
REQ-020 SHALL ignore start in RUN and SHALL ignore pause outside RUN.
REQ-021 In DONE: SHALL hold cycle_count at NUM_CYCLES; start=1 SHALL return to RUN with cycle_count=0 on the same edge.
REQ-022 SHALL never let cycle_count exceed NUM_CYCLES; arithmetic SHALL be 32-bit unsigned with no wrap.

Reset
REQ-023 While reset is low: state=RESET, sync_reset=1, running=0, done=0, cycle_count=0, hold counter=0, synchroniser=0, all asynchronously.
REQ-024 Reset asserted mid-run SHALL abort immediately, with no completion pulse; the full release sequence SHALL repeat from REQ-011.
REQ-025 A reset low pulse shorter than one clock period SHALL still clear all state.

Configuration
REQ-026 With macro RESET_SEQUENCER_AUTORESTART_EN defined: DONE SHALL last exactly one cycle, then transition to RUN with cycle_count=0 regardless of start; done is a 1-cycle pulse per run.
REQ-027 Without RESET_SEQUENCER_AUTORESTART_EN: DONE SHALL persist until start=1 (REQ-021); no autorestart logic SHALL be synthesised.

Verification (RST_CYCLES=2, NUM_CYCLES=5 unless stated)
REQ-028 Reset release, start=0 -> sync_reset=1 through edge 4, sync_reset=0 from edge 5, state IDLE; running=0, done=0, cycle_count=0.
REQ-029 Start pulsed 1 cycle in IDLE, pause=0 -> running=1 for 5 cycles; cycle_count 0,1,2,3,4, then 5 with done=1 and running=0; holds while start=0.
REQ-030 Pause high for 3 cycles at cycle_count=2 -> count stays 2 for 3 cycles; done is asserted 8 cycles after the start edge.
REQ-031 Reset low for 0.4 clock period at cycle_count=3 -> all outputs at reset values at once; release sequence repeats (sync_reset falls on 5th edge).
REQ-032 start=1 held continuously, macro undefined -> DONE lasts 1 cycle, RUN re-entered with count 0; with macro defined and start=0 -> identical periodic 6-cycle run/done pattern.
REQ-033 NUM_CYCLES=1, RST_CYCLES=1, start pulsed -> running=1 for 1 cycle, cycle_count=1, done=1; sync_reset falls on edge 4.
